// File: rtl/cpu_pkg.sv
// Shared CPU encodings: memory/control op codes, exception codes and enable polarities.
package cpu_pkg;

    typedef enum logic [1:0] {
        MEM_OP_NOP = 2'h0,
        MEM_OP_LDW = 2'h1,
        MEM_OP_STW = 2'h2
    } mem_op_e;

    typedef enum logic [1:0] {
        CTRL_OP_NOP  = 2'h0,
        CTRL_OP_WRCR = 2'h1,
        CTRL_OP_EXRT = 2'h2
    } ctrl_op_e;

    typedef enum logic [2:0] {
        EXP_NO_EXP     = 3'h0,
        EXP_EXT_INT    = 3'h1,
        EXP_UNDEF_INSN = 3'h2,
        EXP_OVERFLOW   = 3'h3,
        EXP_MISS_ALIGN = 3'h4,
        EXP_TRAP       = 3'h5,
        EXP_PRV_VIO    = 3'h6
    } exp_code_e;

    localparam logic ENABLE   = 1'b1;
    localparam logic DISABLE  = 1'b0;
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

endpackage

// File: rtl/ex_reg.sv
// EX/MEM pipeline register: captures ALU result and forwarded ID control fields,
// turning a signed overflow on a valid instruction into a precise exception.
module ex_reg
    import cpu_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 30,
    parameter int REG_ADDR_W = 5,
    parameter int MEM_OP_W   = 2,
    parameter int CTRL_OP_W  = 2,
    parameter int EXP_W      = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     alu_out,
    input  logic                  alu_of,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  int_detect,
    input  logic [ADDR_W-1:0]     ex_pc,
    input  logic                  ex_en,
    input  logic                  ex_br_flag,
    input  logic [MEM_OP_W-1:0]   ex_mem_op,
    input  logic [DATA_W-1:0]     ex_mem_wr_data,
    input  logic [CTRL_OP_W-1:0]  ex_ctrl_op,
    input  logic [REG_ADDR_W-1:0] ex_dst_addr,
    input  logic                  ex_gpr_we_,
    input  logic [EXP_W-1:0]      ex_exp_code,
    output logic [ADDR_W-1:0]     mem_pc,
    output logic                  mem_en,
    output logic                  mem_br_flag,
    output logic [MEM_OP_W-1:0]   mem_mem_op,
    output logic [DATA_W-1:0]     mem_mem_wr_data,
    output logic [CTRL_OP_W-1:0]  mem_ctrl_op,
    output logic [REG_ADDR_W-1:0] mem_dst_addr,
    output logic                  mem_gpr_we_,
    output logic [EXP_W-1:0]      mem_exp_code,
    output logic [DATA_W-1:0]     mem_out
);

    localparam logic [MEM_OP_W-1:0]  MEM_NOP  = MEM_OP_W'(MEM_OP_NOP);
    localparam logic [CTRL_OP_W-1:0] CTRL_NOP = CTRL_OP_W'(CTRL_OP_NOP);
    localparam logic [EXP_W-1:0]     NO_EXP   = EXP_W'(EXP_NO_EXP);
    localparam logic [EXP_W-1:0]     OVF_EXP  = EXP_W'(EXP_OVERFLOW);

    logic [ADDR_W-1:0]     mem_pc_q,          mem_pc_d;
    logic                  mem_en_q,          mem_en_d;
    logic                  mem_br_flag_q,     mem_br_flag_d;
    logic [MEM_OP_W-1:0]   mem_mem_op_q,      mem_mem_op_d;
    logic [DATA_W-1:0]     mem_mem_wr_data_q, mem_mem_wr_data_d;
    logic [CTRL_OP_W-1:0]  mem_ctrl_op_q,     mem_ctrl_op_d;
    logic [REG_ADDR_W-1:0] mem_dst_addr_q,    mem_dst_addr_d;
    logic                  mem_gpr_we_q,      mem_gpr_we_d;
    logic [EXP_W-1:0]      mem_exp_code_q,    mem_exp_code_d;
    logic [DATA_W-1:0]     mem_out_q,         mem_out_d;

    always_comb begin
        mem_pc_d          = mem_pc_q;
        mem_en_d          = mem_en_q;
        mem_br_flag_d     = mem_br_flag_q;
        mem_mem_op_d      = mem_mem_op_q;
        mem_mem_wr_data_d = mem_mem_wr_data_q;
        mem_ctrl_op_d     = mem_ctrl_op_q;
        mem_dst_addr_d    = mem_dst_addr_q;
        mem_gpr_we_d      = mem_gpr_we_q;
        mem_exp_code_d    = mem_exp_code_q;
        mem_out_d         = mem_out_q;

        if (!stall) begin
            if (flush || int_detect) begin
                mem_pc_d          = '0;
                mem_en_d          = DISABLE;
                mem_br_flag_d     = 1'b0;
                mem_mem_op_d      = MEM_NOP;
                mem_mem_wr_data_d = '0;
                mem_ctrl_op_d     = CTRL_NOP;
                mem_dst_addr_d    = '0;
                mem_gpr_we_d      = DISABLE_;
                mem_exp_code_d    = NO_EXP;
                mem_out_d         = '0;
            end else begin
                mem_pc_d          = ex_pc;
                mem_en_d          = ex_en;
                mem_br_flag_d     = ex_br_flag;
                mem_mem_wr_data_d = ex_mem_wr_data;
                mem_dst_addr_d    = ex_dst_addr;
                mem_out_d         = alu_out;
                // Side effects are cancelled unless a valid, exception-free op gets through.
                mem_mem_op_d      = MEM_NOP;
                mem_ctrl_op_d     = CTRL_NOP;
                mem_gpr_we_d      = DISABLE_;
                mem_exp_code_d    = NO_EXP;
                if (ex_en) begin
                    if (ex_exp_code != NO_EXP) begin
                        mem_exp_code_d = ex_exp_code;
                    end else if (alu_of) begin
                        mem_exp_code_d = OVF_EXP;
                    end else begin
                        mem_mem_op_d   = ex_mem_op;
                        mem_ctrl_op_d  = ex_ctrl_op;
                        mem_gpr_we_d   = ex_gpr_we_;
                        mem_exp_code_d = ex_exp_code;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_pc_q          <= '0;
            mem_en_q          <= DISABLE;
            mem_br_flag_q     <= 1'b0;
            mem_mem_op_q      <= MEM_NOP;
            mem_mem_wr_data_q <= '0;
            mem_ctrl_op_q     <= CTRL_NOP;
            mem_dst_addr_q    <= '0;
            mem_gpr_we_q      <= DISABLE_;
            mem_exp_code_q    <= NO_EXP;
            mem_out_q         <= '0;
        end else begin
            mem_pc_q          <= mem_pc_d;
            mem_en_q          <= mem_en_d;
            mem_br_flag_q     <= mem_br_flag_d;
            mem_mem_op_q      <= mem_mem_op_d;
            mem_mem_wr_data_q <= mem_mem_wr_data_d;
            mem_ctrl_op_q     <= mem_ctrl_op_d;
            mem_dst_addr_q    <= mem_dst_addr_d;
            mem_gpr_we_q      <= mem_gpr_we_d;
            mem_exp_code_q    <= mem_exp_code_d;
            mem_out_q         <= mem_out_d;
        end
    end

    assign mem_pc          = mem_pc_q;
    assign mem_en          = mem_en_q;
    assign mem_br_flag     = mem_br_flag_q;
    assign mem_mem_op      = mem_mem_op_q;
    assign mem_mem_wr_data = mem_mem_wr_data_q;
    assign mem_ctrl_op     = mem_ctrl_op_q;
    assign mem_dst_addr    = mem_dst_addr_q;
    assign mem_gpr_we_     = mem_gpr_we_q;
    assign mem_exp_code    = mem_exp_code_q;
    assign mem_out         = mem_out_q;

endmodule

// File: doc/ex_reg.md
Name: ex_reg

Overview:
- EX/MEM pipeline register. It sits directly downstream of the ALU inside the ex_stage wrapper.
- Each cycle it captures the ALU result and overflow flag, together with the control fields forwarded from ID, and presents them to the MEM stage.
- It converts a signed overflow on a valid instruction into a precise overflow exception and cancels that instruction's side effects.
- It honours pipeline stall, pipeline flush and interrupt-detect requests.

Parameters:
- DATA_W, 32, data word width (ALU result, store data).
- ADDR_W, 30, word-address width of the PC.
- REG_ADDR_W, 5, GPR index width.
- MEM_OP_W, 2, memory-op code width.
- CTRL_OP_W, 2, control-op code width.
- EXP_W, 3, exception-code width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- alu_out  in  DATA_W  ALU result.
- alu_of  in  1  ALU signed-overflow flag (ADDS/SUBS only).
- stall  in  1  hold request from pipeline control.
- flush  in  1  bubble request from pipeline control.
- int_detect  in  1  interrupt taken; squash the instruction now leaving EX.
- ex_pc  in  ADDR_W  PC of the instruction in EX.
- ex_en  in  1  EX slot holds a valid instruction.
- ex_br_flag  in  1  instruction is a branch.
- ex_mem_op  in  MEM_OP_W  memory op.
- ex_mem_wr_data  in  DATA_W  store data.
- ex_ctrl_op  in  CTRL_OP_W  control op.
- ex_dst_addr  in  REG_ADDR_W  GPR destination.
- ex_gpr_we_  in  1  GPR write enable, active-low.
- ex_exp_code  in  EXP_W  exception raised upstream.
- mem_pc, mem_en, mem_br_flag, mem_mem_op, mem_mem_wr_data, mem_ctrl_op, mem_dst_addr, mem_gpr_we_, mem_exp_code  out  same widths as ex_* counterparts  registered to MEM.
- mem_out  out  DATA_W  registered ALU result (address for loads/stores).

Behaviour:
- Latency: one cycle. Inputs sampled at edge N appear on mem_* after edge N. There is no combinational path from input to output.
- Reset (async assert, sync release):
  - mem_pc=0, mem_en=0, mem_br_flag=0.
  - mem_mem_op=MEM_OP_NOP, mem_mem_wr_data=0, mem_ctrl_op=CTRL_OP_NOP.
  - mem_dst_addr=0, mem_gpr_we_=1 (disabled), mem_exp_code=EXP_NO_EXP, mem_out=0.
- Per-edge priority (highest first): reset > stall > flush|int_detect > capture.
- Stall=1: every output holds its value. A flush or int_detect asserted during a stall is ignored for that cycle; control re-asserts it after the stall releases.
- Bubble (stall=0 and (flush=1 or int_detect=1)): all outputs load their reset values.
- Capture (stall=0, flush=0, int_detect=0):
  - mem_pc, mem_en, mem_br_flag, mem_dst_addr, mem_mem_wr_data and mem_out copy ex_*/alu_out unconditionally.
  - If ex_en=1 and ex_exp_code!=EXP_NO_EXP: mem_exp_code=ex_exp_code. Upstream exceptions are older and take precedence over overflow. In addition, mem_mem_op=NOP, mem_ctrl_op=NOP and mem_gpr_we_=1.
  - Else if ex_en=1 and alu_of=1: mem_exp_code=EXP_OVERFLOW, mem_mem_op=NOP, mem_ctrl_op=NOP, mem_gpr_we_=1. mem_pc is kept so the exception handler can read the EPC.
  - Else if ex_en=1: mem_mem_op, mem_ctrl_op, mem_gpr_we_ and mem_exp_code copy their ex_* inputs.
  - ex_en=0: mem_en=0, mem_mem_op=NOP, mem_ctrl_op=NOP, mem_gpr_we_=1, mem_exp_code=EXP_NO_EXP. alu_of is ignored.
- alu_of is meaningful only for ADDS/SUBS. The block does not decode the op; it trusts the ALU to hold alu_of low for all other ops.
- Back-to-back overflow instructions each raise an exception; there is no sticky state.
- If reset asserts mid-stall, outputs clear immediately. After release, the first edge with no stall or bubble request performs a normal capture.

Decomposition:
- Shared package cpu_pkg holds:
  - MEM_OP_NOP/LDW/STW.
  - CTRL_OP_NOP/WRCR/EXRT.
  - EXP_NO_EXP=3'h0, EXP_EXT_INT, EXP_UNDEF_INSN, EXP_OVERFLOW=3'h3, EXP_MISS_ALIGN, EXP_TRAP, EXP_PRV_VIO.
  - ENABLE/DISABLE and active-low ENABLE_/DISABLE_.
- No sub-module. The ex_stage wrapper instantiates alu and ex_reg side by side.

Test Plan:
- Reset: assert reset mid-cycle with garbage on the inputs -> outputs clear at once to mem_en=0, mem_gpr_we_=1, mem_exp_code=0, mem_out=0.
- Normal capture: ex_en=1, alu_out=32'h0000_0005, ex_dst_addr=5'd3, ex_gpr_we_=0 -> next cycle mem_out=5, mem_dst_addr=3, mem_gpr_we_=0, mem_exp_code=0.
- Overflow: ex_en=1, alu_out=32'h8000_0000, alu_of=1, ex_mem_op=STW, ex_pc=30'h100 -> mem_exp_code=EXP_OVERFLOW, mem_mem_op=NOP, mem_gpr_we_=1, mem_pc=30'h100.
- Exception precedence: ex_exp_code=EXP_UNDEF_INSN together with alu_of=1 -> mem_exp_code=EXP_UNDEF_INSN.
- Stall and flush: capture value A, then 3 cycles of stall=1 with flush=1 in cycle 2 -> outputs hold A for all 3 cycles. Then stall=0, flush=1 -> bubble (mem_en=0, mem_gpr_we_=1).
- Invalid slot: ex_en=0, alu_of=1, ex_gpr_we_=0 -> mem_en=0, mem_gpr_we_=1, mem_exp_code=EXP_NO_EXP.
